// File: rtl/stepgen_pkg.sv
// Shared types and constants for the STEP/DIR pulse engine and its register map.
package stepgen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIRSET,
        ST_HIGH,
        ST_LOW,
        ST_DONE
    } state_t;

    localparam int unsigned DEF_PULSE_HIGH_CYC = 4;
    localparam int unsigned DEF_DIR_SETUP_CYC  = 10;

    // Bit positions in the read-only status register
    localparam int unsigned STAT_BUSY_BIT    = 0;
    localparam int unsigned STAT_ABORTED_BIT = 1;

endpackage

// File: rtl/stepgen_phase_timer.sv
// Loadable down-counter timing the DIRSET, HIGH and LOW phases.
// Loading value D-1 makes o_zero rise D-1 cycles later, so the owning state
// lasts exactly D cycles.
module stepgen_phase_timer #(
    parameter int unsigned W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Count down to zero and hold there until reloaded
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/stepgen_pulse_core.sv
// STEP/DIR pulse engine: runs move commands from the register bank, tracks
// absolute position and reports status. All outputs are registered.
module stepgen_pulse_core
    import stepgen_pkg::*;
#(
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned PULSE_HIGH_CYC = DEF_PULSE_HIGH_CYC,
    parameter int unsigned DIR_SETUP_CYC  = DEF_DIR_SETUP_CYC
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             enable,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [CNT_W-1:0] cmd_period,
    input  logic             cmd_dir,
    input  logic             abort,
    input  logic             pos_load,
    input  logic [CNT_W-1:0] pos_value,
    output logic             step_out,
    output logic             dir_out,
    output logic             busy,
    output logic             done_pulse,
    output logic             aborted,
    output logic [CNT_W-1:0] steps_remaining,
    output logic [CNT_W-1:0] position
);

    localparam logic [CNT_W-1:0] C_MIN_PERIOD = CNT_W'(PULSE_HIGH_CYC + 1);
    localparam logic [CNT_W-1:0] C_HIGH_LOAD  = CNT_W'(PULSE_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] C_DIR_LOAD   = CNT_W'(DIR_SETUP_CYC - 1);

    state_t           r_state, w_state_next;
    logic             r_cmd_ready, r_step, r_dir, r_busy, r_done, r_aborted;
    logic             r_abort_pend;
    logic [CNT_W-1:0] r_steps, r_pos, r_low_load;
    logic             w_abort_req, w_accept, w_abort_end, w_enter_high;
    logic             w_tmr_load, w_tmr_zero;
    logic [CNT_W-1:0] w_tmr_value, w_eff_period;

    assign w_abort_req  = abort | ~enable;
    assign w_accept     = (r_state == ST_IDLE) & r_cmd_ready & cmd_valid;
    assign w_eff_period = (cmd_period < C_MIN_PERIOD) ? C_MIN_PERIOD : cmd_period;
    assign w_enter_high = (w_state_next == ST_HIGH) && (r_state != ST_HIGH);

    stepgen_phase_timer #(.W(CNT_W)) u_timer (
        .i_clk   (ACLK),
        .i_rst_n (ARESETN),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_value),
        .o_zero  (w_tmr_zero)
    );

    // Next-state logic and phase timer loading
    always_comb begin
        w_state_next = r_state;
        w_tmr_load   = 1'b0;
        w_tmr_value  = '0;
        w_abort_end  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (cmd_steps == '0) begin
                        w_state_next = ST_DONE;
                    end else begin
                        // Without a direction change DIRSET is a single cycle,
                        // which gives the one-cycle accept-to-STEP latency.
                        w_state_next = ST_DIRSET;
                        w_tmr_load   = 1'b1;
                        w_tmr_value  = (cmd_dir != r_dir) ? C_DIR_LOAD : '0;
                    end
                end
            end
            ST_DIRSET: begin
                if (w_abort_req) begin
                    w_state_next = ST_DONE;
                    w_abort_end  = 1'b1;
                end else if (w_tmr_zero) begin
                    w_state_next = ST_HIGH;
                    w_tmr_load   = 1'b1;
                    w_tmr_value  = C_HIGH_LOAD;
                end
            end
            ST_HIGH: begin
                if (w_tmr_zero) begin
                    if (w_abort_req || r_abort_pend) begin
                        w_state_next = ST_DONE;
                        w_abort_end  = 1'b1;
                    end else begin
                        w_state_next = ST_LOW;
                        w_tmr_load   = 1'b1;
                        w_tmr_value  = r_low_load;
                    end
                end
            end
            ST_LOW: begin
                if (w_abort_req) begin
                    w_state_next = ST_DONE;
                    w_abort_end  = 1'b1;
                end else if (w_tmr_zero) begin
                    if (r_steps == '0) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_HIGH;
                        w_tmr_load   = 1'b1;
                        w_tmr_value  = C_HIGH_LOAD;
                    end
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register and registered pin/status outputs derived from next state
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state      <= ST_IDLE;
            r_cmd_ready  <= 1'b0;
            r_step       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_abort_pend <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cmd_ready  <= (w_state_next == ST_IDLE) && enable;
            r_step       <= (w_state_next == ST_HIGH);
            r_busy       <= (w_state_next == ST_DIRSET) || (w_state_next == ST_HIGH) ||
                            (w_state_next == ST_LOW);
            r_done       <= (w_state_next == ST_DONE);
            // An abort seen anywhere in a high phase is held until the phase ends
            r_abort_pend <= (r_state == ST_HIGH) && (w_state_next == ST_HIGH) &&
                            (r_abort_pend || w_abort_req);
        end
    end

    // Command latch, step/position bookkeeping and sticky abort flag
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_dir      <= 1'b0;
            r_steps    <= '0;
            r_pos      <= '0;
            r_low_load <= '0;
            r_aborted  <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && pos_load) begin
                r_pos <= pos_value;
            end
            if (w_accept) begin
                r_steps    <= cmd_steps;
                r_low_load <= w_eff_period - C_MIN_PERIOD;
                r_aborted  <= 1'b0;
                if (cmd_steps != '0) begin
                    r_dir <= cmd_dir;
                end
            end
            if (w_enter_high) begin
                r_steps <= r_steps - CNT_W'(1);
                r_pos   <= r_dir ? (r_pos + CNT_W'(1)) : (r_pos - CNT_W'(1));
            end
            if (w_abort_end) begin
                r_steps   <= '0;
                r_aborted <= 1'b1;
            end
        end
    end

    assign cmd_ready       = r_cmd_ready;
    assign step_out        = r_step;
    assign dir_out         = r_dir;
    assign busy            = r_busy;
    assign done_pulse      = r_done;
    assign aborted         = r_aborted;
    assign steps_remaining = r_steps;
    assign position        = r_pos;

endmodule

// File: tb/tb_stepgen_pulse_core.sv
// Scenario bench for stepgen_pulse_core: expected STEP edges, pulse widths and
// done strobes are queued at command time and compared with what a monitor sees.
module tb_stepgen_pulse_core;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        enable = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_dir = 1'b0;
    logic        abort = 1'b0;
    logic        pos_load = 1'b0;
    logic [31:0] cmd_steps = '0;
    logic [31:0] cmd_period = '0;
    logic [31:0] pos_value = '0;
    logic        cmd_ready, step_out, dir_out, busy, done_pulse, aborted;
    logic [31:0] steps_remaining, position;

    int tests_run = 0;
    int tests_failed = 0;

    stepgen_pulse_core #(.CNT_W(32), .PULSE_HIGH_CYC(4), .DIR_SETUP_CYC(10)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_steps(cmd_steps),
        .cmd_period(cmd_period), .cmd_dir(cmd_dir), .abort(abort),
        .pos_load(pos_load), .pos_value(pos_value), .step_out(step_out),
        .dir_out(dir_out), .busy(busy), .done_pulse(done_pulse), .aborted(aborted),
        .steps_remaining(steps_remaining), .position(position)
    );

    always #10 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    // Scoreboard queues: expected (pushed by tests) and observed (pushed by monitor)
    int exp_rise[$], exp_hlen[$], exp_done[$];
    int obs_rise[$], obs_hlen[$], obs_done[$];
    int n_done = 0, dir_chg_cyc = -1, hi_start = 0;
    logic prev_step = 1'b0, prev_dir = 1'b0;

    always @(posedge ACLK) begin
        #1;
        if (step_out && !prev_step) begin
            obs_rise.push_back(cyc);
            hi_start = cyc;
        end
        if (!step_out && prev_step) obs_hlen.push_back(cyc - hi_start);
        if (done_pulse) begin
            obs_done.push_back(cyc);
            n_done++;
        end
        if (dir_out !== prev_dir) dir_chg_cyc = cyc;
        prev_step = step_out;
        prev_dir  = dir_out;
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic clear_sb();
        exp_rise.delete(); exp_hlen.delete(); exp_done.delete();
        obs_rise.delete(); obs_hlen.delete(); obs_done.delete();
        dir_chg_cyc = -1;
    endtask

    task automatic send_cmd(input logic [31:0] s, input logic [31:0] p, input logic d,
                            output int acc);
        for (int i = 0; i < 50 && cmd_ready !== 1'b1; i++) tick();
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL cmd_ready_wait got=%b exp=1", cmd_ready);
        end
        cmd_steps = s; cmd_period = p; cmd_dir = d; cmd_valid = 1'b1;
        tick();
        acc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int n0, input int bound);
        for (int i = 0; i < bound && n_done == n0; i++) tick();
        repeat (2) tick();
    endtask

    task automatic test_reset();
        int acc, seen;
        logic ps;
        ARESETN = 1'b0; enable = 1'b1;
        repeat (3) tick();
        tests_run++;
        if ({cmd_ready, step_out, dir_out, busy, done_pulse, aborted} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {cmd_ready, step_out, dir_out, busy, done_pulse, aborted});
        end
        tests_run++;
        if ({steps_remaining, position} !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_counts got=%h/%h exp=0/0", steps_remaining, position);
        end
        ARESETN = 1'b1;
        tick();
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready got=%b exp=1", cmd_ready);
        end
        // Reset in the middle of a move, right after the third STEP edge
        send_cmd(32'd10, 32'd20, 1'b1, acc);
        seen = 0; ps = 1'b0;
        for (int i = 0; i < 300 && seen < 3; i++) begin
            tick();
            if (step_out && !ps) seen++;
            ps = step_out;
        end
        tests_run++;
        if (position !== 32'd3 || step_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL midmove_pre got=pos %h step %b exp=pos 3 step 1", position, step_out);
        end
        ARESETN = 1'b0;
        tick();
        tests_run++;
        if ({cmd_ready, step_out, dir_out, busy, done_pulse, aborted} !== 6'b0) begin
            tests_failed++;
            $display("FAIL midmove_reset_flags got=%b exp=000000",
                     {cmd_ready, step_out, dir_out, busy, done_pulse, aborted});
        end
        tests_run++;
        if ({steps_remaining, position} !== 64'h0) begin
            tests_failed++;
            $display("FAIL midmove_reset_counts got=%h/%h exp=0/0", steps_remaining, position);
        end
        ARESETN = 1'b1;
        tick();
        tests_run++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midmove_release got=ready %b busy %b exp=1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_basic();
        int acc, n0, e, o;
        clear_sb();
        n0 = n_done;
        send_cmd(32'd5, 32'd20, 1'b0, acc);
        for (int k = 0; k < 5; k++) begin
            exp_rise.push_back(acc + 1 + 20 * k);
            exp_hlen.push_back(4);
        end
        exp_done.push_back(acc + 1 + 100);
        wait_done(n0, 400);
        tests_run++;
        if (obs_rise.size() !== exp_rise.size() || obs_hlen.size() !== exp_hlen.size() ||
            obs_done.size() !== exp_done.size()) begin
            tests_failed++;
            $display("FAIL basic_counts got=%0d/%0d/%0d exp=%0d/%0d/%0d", obs_rise.size(),
                     obs_hlen.size(), obs_done.size(), exp_rise.size(), exp_hlen.size(),
                     exp_done.size());
        end
        while (exp_rise.size() > 0 && obs_rise.size() > 0) begin
            e = exp_rise.pop_front(); o = obs_rise.pop_front(); tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL basic_rise got=%0d exp=%0d", o, e); end
        end
        while (exp_hlen.size() > 0 && obs_hlen.size() > 0) begin
            e = exp_hlen.pop_front(); o = obs_hlen.pop_front(); tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL basic_hlen got=%0d exp=%0d", o, e); end
        end
        while (exp_done.size() > 0 && obs_done.size() > 0) begin
            e = exp_done.pop_front(); o = obs_done.pop_front(); tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL basic_done got=%0d exp=%0d", o, e); end
        end
        tests_run++;
        if (position !== 32'hFFFF_FFFB || steps_remaining !== 32'd0 || aborted !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_status got=pos %h rem %h ab %b exp=pos fffffffb rem 0 ab 0",
                     position, steps_remaining, aborted);
        end
        tests_run++;
        if (dir_chg_cyc !== -1) begin
            tests_failed++;
            $display("FAIL basic_no_dirset got=%0d exp=-1", dir_chg_cyc);
        end
    endtask

    task automatic test_dir_change();
        int acc, n0, e, o;
        clear_sb();
        n0 = n_done;
        send_cmd(32'd3, 32'd100, 1'b1, acc);
        for (int k = 0; k < 3; k++) exp_rise.push_back(acc + 10 + 100 * k);
        exp_done.push_back(acc + 10 + 300);
        wait_done(n0, 600);
        tests_run++;
        if (dir_chg_cyc !== acc) begin
            tests_failed++;
            $display("FAIL dir_change_time got=%0d exp=%0d", dir_chg_cyc, acc);
        end
        tests_run++;
        if (obs_rise.size() !== exp_rise.size() || obs_done.size() !== exp_done.size()) begin
            tests_failed++;
            $display("FAIL dir_counts got=%0d/%0d exp=%0d/%0d", obs_rise.size(), obs_done.size(),
                     exp_rise.size(), exp_done.size());
        end
        while (exp_rise.size() > 0 && obs_rise.size() > 0) begin
            e = exp_rise.pop_front(); o = obs_rise.pop_front(); tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL dir_rise got=%0d exp=%0d", o, e); end
        end
        while (exp_done.size() > 0 && obs_done.size() > 0) begin
            e = exp_done.pop_front(); o = obs_done.pop_front(); tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL dir_done got=%0d exp=%0d", o, e); end
        end
        tests_run++;
        if (position !== 32'hFFFF_FFFE || dir_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL dir_position got=%h dir %b exp=fffffffe dir 1", position, dir_out);
        end
    endtask

    task automatic test_clamp();
        int acc, n0, e, o;
        logic [31:0] p0;
        clear_sb();
        n0 = n_done;
        p0 = position;
        send_cmd(32'd2, 32'd2, 1'b1, acc);
        exp_rise.push_back(acc + 1); exp_rise.push_back(acc + 6);
        exp_hlen.push_back(4); exp_hlen.push_back(4);
        exp_done.push_back(acc + 11);
        wait_done(n0, 100);
        tests_run++;
        if (obs_rise.size() !== exp_rise.size() || obs_hlen.size() !== exp_hlen.size() ||
            obs_done.size() !== exp_done.size()) begin
            tests_failed++;
            $display("FAIL clamp_counts got=%0d/%0d/%0d exp=2/2/1", obs_rise.size(),
                     obs_hlen.size(), obs_done.size());
        end
        while (exp_rise.size() > 0 && obs_rise.size() > 0) begin
            e = exp_rise.pop_front(); o = obs_rise.pop_front(); tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL clamp_rise got=%0d exp=%0d", o, e); end
        end
        while (exp_hlen.size() > 0 && obs_hlen.size() > 0) begin
            e = exp_hlen.pop_front(); o = obs_hlen.pop_front(); tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL clamp_hlen got=%0d exp=%0d", o, e); end
        end
        while (exp_done.size() > 0 && obs_done.size() > 0) begin
            e = exp_done.pop_front(); o = obs_done.pop_front(); tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL clamp_done got=%0d exp=%0d", o, e); end
        end
        tests_run++;
        if (position !== p0 + 32'd2) begin
            tests_failed++;
            $display("FAIL clamp_position got=%h exp=%h", position, p0 + 32'd2);
        end
    endtask

    task automatic test_abort();
        int acc, n0, e, o, seen;
        logic ps;
        logic [31:0] p0;
        clear_sb();
        n0 = n_done;
        p0 = position;
        send_cmd(32'd1000, 32'd50, 1'b1, acc);
        exp_rise.push_back(acc + 1); exp_rise.push_back(acc + 51);
        exp_hlen.push_back(4); exp_hlen.push_back(4);
        seen = 0; ps = 1'b0;
        for (int i = 0; i < 300 && seen < 2; i++) begin
            tick();
            if (step_out && !ps) seen++;
            ps = step_out;
        end
        abort = 1'b1;
        exp_done.push_back(cyc + 4);
        wait_done(n0, 100);
        abort = 1'b0;
        tests_run++;
        if (obs_rise.size() !== exp_rise.size() || obs_hlen.size() !== exp_hlen.size() ||
            obs_done.size() !== exp_done.size()) begin
            tests_failed++;
            $display("FAIL abort_counts got=%0d/%0d/%0d exp=2/2/1", obs_rise.size(),
                     obs_hlen.size(), obs_done.size());
        end
        while (exp_rise.size() > 0 && obs_rise.size() > 0) begin
            e = exp_rise.pop_front(); o = obs_rise.pop_front(); tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL abort_rise got=%0d exp=%0d", o, e); end
        end
        while (exp_hlen.size() > 0 && obs_hlen.size() > 0) begin
            e = exp_hlen.pop_front(); o = obs_hlen.pop_front(); tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL abort_hlen got=%0d exp=%0d", o, e); end
        end
        while (exp_done.size() > 0 && obs_done.size() > 0) begin
            e = exp_done.pop_front(); o = obs_done.pop_front(); tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL abort_done got=%0d exp=%0d", o, e); end
        end
        tests_run++;
        if (aborted !== 1'b1 || steps_remaining !== 32'd0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_status got=ab %b rem %h busy %b exp=1 0 0",
                     aborted, steps_remaining, busy);
        end
        tests_run++;
        if (position !== p0 + 32'd2) begin
            tests_failed++;
            $display("FAIL abort_position got=%h exp=%h", position, p0 + 32'd2);
        end
        repeat (5) tick();
        tests_run++;
        if (aborted !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_sticky got=%b exp=1", aborted);
        end
    endtask

    task automatic test_wrap_and_zero();
        int acc, n0, e, o;
        logic [31:0] p0;
        clear_sb();
        n0 = n_done;
        pos_value = 32'h7FFF_FFFF;
        pos_load = 1'b1;
        send_cmd(32'd1, 32'd5, 1'b1, acc);
        pos_load = 1'b0;
        exp_rise.push_back(acc + 1);
        exp_done.push_back(acc + 6);
        tests_run++;
        if (aborted !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_abort_clear got=%b exp=0", aborted);
        end
        tick();
        pos_value = 32'h1234_5678;
        pos_load = 1'b1;
        tick();
        pos_load = 1'b0;
        wait_done(n0, 50);
        while (exp_rise.size() > 0 && obs_rise.size() > 0) begin
            e = exp_rise.pop_front(); o = obs_rise.pop_front(); tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL wrap_rise got=%0d exp=%0d", o, e); end
        end
        while (exp_done.size() > 0 && obs_done.size() > 0) begin
            e = exp_done.pop_front(); o = obs_done.pop_front(); tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL wrap_done got=%0d exp=%0d", o, e); end
        end
        tests_run++;
        if (position !== 32'h8000_0000) begin
            tests_failed++;
            $display("FAIL wrap_position got=%h exp=80000000", position);
        end
        // Zero-step command: immediate done strobe, no STEP activity
        clear_sb();
        n0 = n_done;
        p0 = position;
        send_cmd(32'd0, 32'd20, 1'b1, acc);
        exp_done.push_back(acc);
        wait_done(n0, 20);
        tests_run++;
        if (obs_rise.size() !== 0 || obs_done.size() !== exp_done.size()) begin
            tests_failed++;
            $display("FAIL zero_counts got=rise %0d done %0d exp=rise 0 done 1",
                     obs_rise.size(), obs_done.size());
        end
        while (exp_done.size() > 0 && obs_done.size() > 0) begin
            e = exp_done.pop_front(); o = obs_done.pop_front(); tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL zero_done got=%0d exp=%0d", o, e); end
        end
        tests_run++;
        if (position !== p0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_status got=pos %h ready %b busy %b exp=pos %h 1 0",
                     position, cmd_ready, busy, p0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_dir_change();
        test_clamp();
        test_abort();
        test_wrap_and_zero();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
